// File: rtl/caliptra_sram_err_inject.sv
// rtl/caliptra_sram_err_inject.sv - multi-channel SRAM write-path bitflip injector
//
// Sits between each SRAM requester and its SRAM, producing a per-channel mask
// that is XORed onto wdata. Each channel runs in its own mode: off, continuous,
// one-shot or periodic, with single- or double-bit masks at a rotating position.
//
// Ports:
//   clk, rst_b   harness clock, asynchronous active-low reset
//   cfg_mode     per-channel mode, channel i at [3i+:3]
//   cfg_period   per-channel period for periodic modes, channel i at [CNT_W*i+:CNT_W]
//   cfg_arm      one-cycle pulse per channel: arm a one-shot injection
//   cnt_clr      one-cycle pulse per channel: clear inj_count
//   sram_cs      per-channel chip select
//   sram_we      per-channel write enable
//   bitflip      per-channel mask, channel i at [DATA_W*i+:DATA_W]
//   armed        per-channel one-shot armed status
//   inj_count    per-channel saturating injection count
module caliptra_sram_err_inject #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 39,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [NUM_CH*3-1:0]      cfg_mode,
    input  logic [NUM_CH*CNT_W-1:0]  cfg_period,
    input  logic [NUM_CH-1:0]        cfg_arm,
    input  logic [NUM_CH-1:0]        cnt_clr,
    input  logic [NUM_CH-1:0]        sram_cs,
    input  logic [NUM_CH-1:0]        sram_we,
    output logic [NUM_CH*DATA_W-1:0] bitflip,
    output logic [NUM_CH-1:0]        armed,
    output logic [NUM_CH*CNT_W-1:0]  inj_count
);

    localparam int POS_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(DATA_W - 1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [2:0]        mode;
        logic [CNT_W-1:0]  period_eff;
        logic              wr;
        logic              mode_chg;
        logic              is_cont;
        logic              is_one;
        logic              is_per;
        logic              dbl;
        logic              inj;
        logic [POS_W-1:0]  pos_nxt;
        logic [DATA_W-1:0] mask;

        logic [POS_W-1:0]  pos_q, pos_d;
        logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
        logic              armed_q, armed_d;
        logic [CNT_W-1:0]  inj_cnt_q, inj_cnt_d;
        logic [2:0]        prev_mode_q;

        assign mode       = cfg_mode[3*g +: 3];
        assign period_eff = (cfg_period[CNT_W*g +: CNT_W] == '0) ? CNT_W'(1)
                                                                 : cfg_period[CNT_W*g +: CNT_W];
        assign wr         = sram_cs[g] & sram_we[g];
        assign mode_chg   = (mode != prev_mode_q);
        assign is_cont    = (mode == 3'd1) || (mode == 3'd2);
        assign is_one     = (mode == 3'd3) || (mode == 3'd4);
        assign is_per     = (mode == 3'd5) || (mode == 3'd6);
        assign dbl        = (mode == 3'd2) || (mode == 3'd4) || (mode == 3'd6);
        assign pos_nxt    = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;

        // Gated by rst_b so the mask is zero while reset is held, even with a
        // write present and a continuous mode selected.
        // The >= compare makes a lowered period take effect on the next write.
        assign inj = rst_b & wr &
                     (is_cont | (is_one & armed_q) |
                      (is_per & (wr_cnt_q >= period_eff - 1'b1)));

        always_comb begin
            mask = '0;
            if (inj) begin
                mask[pos_q] = 1'b1;
                if (dbl) begin
                    mask[pos_nxt] = 1'b1;
                end
            end
        end

        always_comb begin
            pos_d     = pos_q;
            wr_cnt_d  = wr_cnt_q;
            armed_d   = armed_q;
            inj_cnt_d = inj_cnt_q;

            if (mode_chg) begin
                // The change-cycle write already used the old state; restart cleanly.
                pos_d    = '0;
                wr_cnt_d = '0;
                armed_d  = 1'b0;
            end else begin
                if (inj) begin
                    pos_d = pos_nxt;
                end
                if (is_per && wr) begin
                    wr_cnt_d = inj ? '0 : wr_cnt_q + 1'b1;
                end
                // A same-cycle arm outranks the clear caused by an injection.
                if (cfg_arm[g] && is_one) begin
                    armed_d = 1'b1;
                end else if (inj) begin
                    armed_d = 1'b0;
                end
            end

            if (cnt_clr[g]) begin
                inj_cnt_d = '0;
            end else if (inj && !(&inj_cnt_q)) begin
                inj_cnt_d = inj_cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                pos_q       <= '0;
                wr_cnt_q    <= '0;
                armed_q     <= 1'b0;
                inj_cnt_q   <= '0;
                prev_mode_q <= 3'd0;
            end else begin
                pos_q       <= pos_d;
                wr_cnt_q    <= wr_cnt_d;
                armed_q     <= armed_d;
                inj_cnt_q   <= inj_cnt_d;
                prev_mode_q <= mode;
            end
        end

        assign bitflip[DATA_W*g +: DATA_W] = mask;
        assign armed[g]                    = armed_q;
        assign inj_count[CNT_W*g +: CNT_W] = inj_cnt_q;
    end

endmodule
